// File: rtl/fan_ctrl_pkg.sv
// Shared types and default constants for the refrigeration fan speed controller.
package fan_ctrl_pkg;

    localparam int unsigned TEMP_W = 8;
    localparam int unsigned LVL_W  = 2;

    typedef logic [LVL_W-1:0] lvl_t;

    localparam lvl_t LVL_MIN = 2'd0;
    localparam lvl_t LVL_MAX = 2'd3;

    typedef enum logic {
        ST_HOLD = 1'b0,
        ST_RAMP = 1'b1
    } state_t;

    localparam int unsigned T1_DEF             = 20;
    localparam int unsigned T2_DEF             = 26;
    localparam int unsigned T3_DEF             = 32;
    localparam int unsigned HYST_DEF           = 2;
    localparam int unsigned STEP_CYCLES_DEF    = 50_000_000;
    localparam int unsigned TIMEOUT_CYCLES_DEF = 150_000_000;
    localparam int unsigned T_ALARM_DEF        = 40;

endpackage

// File: rtl/fan_speed_ctrl_if.sv
// Sensor-in / speed-out signal bundle of the fan speed controller.
interface fan_speed_ctrl_if;
    import fan_ctrl_pkg::*;

    logic [TEMP_W-1:0] temp;
    logic              temp_valid;
    lvl_t              giro;
    lvl_t              target_lvl;
    logic              step_pulse;
    logic              sensor_fault;
    logic              alarm;

    modport master (
        output temp, temp_valid,
        input  giro, target_lvl, step_pulse, sensor_fault, alarm
    );

    modport slave (
        input  temp, temp_valid,
        output giro, target_lvl, step_pulse, sensor_fault, alarm
    );

endinterface

// File: rtl/fan_level_map.sv
// Temperature to speed level mapping with downward hysteresis; purely combinational.
module fan_level_map
    import fan_ctrl_pkg::*;
#(
    parameter int unsigned T1   = T1_DEF,
    parameter int unsigned T2   = T2_DEF,
    parameter int unsigned T3   = T3_DEF,
    parameter int unsigned HYST = HYST_DEF
) (
    input  logic [TEMP_W-1:0] temp,
    input  lvl_t              cur_lvl,
    output lvl_t              next_lvl_c
);

    // One extra bit so temp + HYST cannot wrap before saturation.
    localparam logic [8:0] T1_W   = 9'(T1);
    localparam logic [8:0] T2_W   = 9'(T2);
    localparam logic [8:0] T3_W   = 9'(T3);
    localparam logic [8:0] HYST_W = 9'(HYST);

    function automatic lvl_t lvl_of(input logic [8:0] t);
        lvl_t n;
        n = LVL_MIN;
        if (t >= T1_W) n = n + 2'd1;
        if (t >= T2_W) n = n + 2'd1;
        if (t >= T3_W) n = n + 2'd1;
        return n;
    endfunction

    logic [8:0] temp_w;
    logic [8:0] temp_up;
    logic [8:0] thr;
    logic [8:0] thr_low;
    lvl_t       lvl_now;

    always_comb begin
        temp_w  = {1'b0, temp};
        temp_up = temp_w + HYST_W;
        if (temp_up > 9'd255) temp_up = 9'd255;
        lvl_now = lvl_of(temp_w);

        case (cur_lvl)
            2'd1:    thr = T1_W;
            2'd2:    thr = T2_W;
            default: thr = T3_W;
        endcase
        thr_low = (thr > HYST_W) ? (thr - HYST_W) : 9'd0;

        next_lvl_c = cur_lvl;
        if (lvl_now > cur_lvl)
            next_lvl_c = lvl_now;
        else if ((cur_lvl != LVL_MIN) && (temp_w < thr_low))
            next_lvl_c = lvl_of(temp_up);
    end

endmodule

// File: rtl/fan_speed_ctrl.sv
// Fan speed selector: hysteresis target, dwell-paced giro ramp, sensor watchdog.
// Optional over-temperature alarm latch enabled by OVERTEMP_ALARM_EN.
module fan_speed_ctrl
    import fan_ctrl_pkg::*;
#(
    parameter int unsigned T1             = T1_DEF,
    parameter int unsigned T2             = T2_DEF,
    parameter int unsigned T3             = T3_DEF,
    parameter int unsigned HYST           = HYST_DEF,
    parameter int unsigned STEP_CYCLES    = STEP_CYCLES_DEF,
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
`ifdef OVERTEMP_ALARM_EN
    ,
    parameter int unsigned T_ALARM        = T_ALARM_DEF
`endif
) (
    input logic             clk,
    input logic             reset,
    fan_speed_ctrl_if.slave bus
);

    localparam int unsigned DW = $clog2(STEP_CYCLES);
    localparam int unsigned WW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [DW-1:0] DWELL_LAST = DW'(STEP_CYCLES - 1);
    localparam logic [WW-1:0] WD_MAX     = WW'(TIMEOUT_CYCLES);

    state_t        state, state_d;
    logic [DW-1:0] dwell, dwell_d;
    logic [WW-1:0] wd, wd_d;
    lvl_t          giro, giro_d;
    lvl_t          target_lvl, target_d;
    lvl_t          map_lvl;
    logic          step_pulse, step_d;
    logic          sensor_fault, fault_d;
    logic          alarm_d;

    fan_level_map #(
        .T1   (T1),
        .T2   (T2),
        .T3   (T3),
        .HYST (HYST)
    ) u_level_map (
        .temp       (bus.temp),
        .cur_lvl    (target_lvl),
        .next_lvl_c (map_lvl)
    );

`ifdef OVERTEMP_ALARM_EN
    localparam logic [8:0] TA_W   = 9'(T_ALARM);
    localparam logic [8:0] TA_LOW = (T_ALARM > HYST) ? 9'(T_ALARM - HYST) : 9'd0;

    logic alarm;

    always_comb begin
        alarm_d = alarm;
        if (bus.temp_valid) begin
            if ({1'b0, bus.temp} >= TA_W)
                alarm_d = 1'b1;
            else if ({1'b0, bus.temp} < TA_LOW)
                alarm_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) alarm <= 1'b0;
        else       alarm <= alarm_d;
    end

    assign bus.alarm = alarm;
`else
    assign alarm_d   = 1'b0;
    assign bus.alarm = 1'b0;
`endif

    // Watchdog and target: a valid sample always beats a coincident timeout.
    always_comb begin
        wd_d     = wd;
        fault_d  = sensor_fault;
        target_d = target_lvl;
        if (bus.temp_valid) begin
            wd_d     = '0;
            fault_d  = 1'b0;
            target_d = alarm_d ? LVL_MAX : map_lvl;
        end else if (wd != WD_MAX) begin
            wd_d = wd + WW'(1);
            if (wd_d == WD_MAX) begin
                fault_d  = 1'b1;
                target_d = LVL_MAX;
            end
        end
    end

    // Ramp FSM decides on the target value being loaded this cycle.
    always_comb begin
        state_d = state;
        dwell_d = dwell;
        giro_d  = giro;
        step_d  = 1'b0;
        case (state)
            ST_HOLD: begin
                dwell_d = '0;
                if (target_d != giro) state_d = ST_RAMP;
            end
            ST_RAMP: begin
                if (target_d == giro) begin
                    state_d = ST_HOLD;
                    dwell_d = '0;
                end else if (dwell == DWELL_LAST) begin
                    dwell_d = '0;
                    step_d  = 1'b1;
                    giro_d  = (target_d > giro) ? (giro + 2'd1) : (giro - 2'd1);
                    if (giro_d == target_d) state_d = ST_HOLD;
                end else begin
                    dwell_d = dwell + DW'(1);
                end
            end
            default: state_d = ST_HOLD;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= ST_HOLD;
            dwell        <= '0;
            wd           <= '0;
            giro         <= LVL_MIN;
            target_lvl   <= LVL_MIN;
            step_pulse   <= 1'b0;
            sensor_fault <= 1'b0;
        end else begin
            state        <= state_d;
            dwell        <= dwell_d;
            wd           <= wd_d;
            giro         <= giro_d;
            target_lvl   <= target_d;
            step_pulse   <= step_d;
            sensor_fault <= fault_d;
        end
    end

    assign bus.giro         = giro;
    assign bus.target_lvl   = target_lvl;
    assign bus.step_pulse   = step_pulse;
    assign bus.sensor_fault = sensor_fault;

endmodule

// File: tb/tb_fan_speed_ctrl.sv
// Directed bench for fan_speed_ctrl with STEP_CYCLES=4, TIMEOUT_CYCLES=64.
module tb_fan_speed_ctrl;

    logic clk = 1'b0;
    logic reset;
    int   n_tests = 0;
    int   n_fail  = 0;

    fan_speed_ctrl_if bif ();

    fan_speed_ctrl #(
        .STEP_CYCLES    (4),
        .TIMEOUT_CYCLES (64)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bif)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic send_valid(input logic [7:0] t);
        bif.temp       = t;
        bif.temp_valid = 1'b1;
        tick();
        bif.temp_valid = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [1:0] got, input logic [1:0] exp);
        n_tests++;
        assert (got === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    initial begin
        reset          = 1'b1;
        bif.temp       = 8'd0;
        bif.temp_valid = 1'b0;
        run(2);
        chk("rst_giro",   bif.giro,               2'd0);
        chk("rst_target", bif.target_lvl,         2'd0);
        chk("rst_step",   2'(bif.step_pulse),     2'd0);
        chk("rst_fault",  2'(bif.sensor_fault),   2'd0);
        chk("rst_alarm",  2'(bif.alarm),          2'd0);
        reset = 1'b0;
        run(1);

        // Cold reading: nothing moves
        send_valid(8'd18);
        chk("t18_target", bif.target_lvl, 2'd0);
        run(4);
        chk("t18_giro",   bif.giro,           2'd0);
        chk("t18_step",   2'(bif.step_pulse), 2'd0);

        // Jump to level 3, giro ramps one level every 4 cycles
        send_valid(8'd33);
        chk("t33_target", bif.target_lvl, 2'd3);
        chk("t33_giro0",  bif.giro,       2'd0);
        run(3);
        chk("ramp_pre1",  bif.giro,           2'd0);
        chk("ramp_pre1s", 2'(bif.step_pulse), 2'd0);
        run(1);
        chk("ramp_g1",    bif.giro,           2'd1);
        chk("ramp_s1",    2'(bif.step_pulse), 2'd1);
        run(1);
        chk("ramp_s1off", 2'(bif.step_pulse), 2'd0);
        run(3);
        chk("ramp_g2",    bif.giro,           2'd2);
        chk("ramp_s2",    2'(bif.step_pulse), 2'd1);
        run(4);
        chk("ramp_g3",    bif.giro,           2'd3);
        chk("ramp_s3",    2'(bif.step_pulse), 2'd1);

        // Hysteresis at level 3: 31 holds, 29 (< 30) drops to lvl(31)=2
        send_valid(8'd31);
        chk("t31_target", bif.target_lvl, 2'd3);
        run(2);
        chk("t31_giro",   bif.giro,           2'd3);
        chk("t31_step",   2'(bif.step_pulse), 2'd0);
        send_valid(8'd29);
        chk("t29_target", bif.target_lvl, 2'd2);
        run(3);
        chk("down_pre",   bif.giro, 2'd3);
        run(1);
        chk("down_g2",    bif.giro,           2'd2);
        chk("down_s",     2'(bif.step_pulse), 2'd1);
        run(1);

        // Watchdog: fault 64 cycles after the last valid sample (5 already elapsed)
        run(58);
        chk("wd_pre_fault",  2'(bif.sensor_fault), 2'd0);
        chk("wd_pre_target", bif.target_lvl,       2'd2);
        run(1);
        chk("wd_fault",      2'(bif.sensor_fault), 2'd1);
        chk("wd_target",     bif.target_lvl,       2'd3);
        run(4);
        chk("wd_giro3",      bif.giro,             2'd3);
        chk("wd_step",       2'(bif.step_pulse),   2'd1);

        // Fault exit with 17: 17 < 30 and 17+2 < T1, so target 0
        send_valid(8'd17);
        chk("fx_fault",  2'(bif.sensor_fault), 2'd0);
        chk("fx_target", bif.target_lvl,       2'd0);
        run(4);
        chk("fx_g2", bif.giro, 2'd2);
        run(8);
        chk("fx_g0", bif.giro,           2'd0);
        chk("fx_s",  2'(bif.step_pulse), 2'd1);

        // Reset while ramping 1 -> 2, one cycle before the step would land
        send_valid(8'd21);
        chk("t21_target", bif.target_lvl, 2'd1);
        run(4);
        chk("t21_giro", bif.giro, 2'd1);
        send_valid(8'd27);
        chk("t27_target", bif.target_lvl, 2'd2);
        run(3);
        chk("mid_giro", bif.giro, 2'd1);
        reset = 1'b1;
        #1;
        chk("arst_giro",   bif.giro,           2'd0);
        chk("arst_step",   2'(bif.step_pulse), 2'd0);
        chk("arst_target", bif.target_lvl,     2'd0);
        run(2);
        chk("arst_step2", 2'(bif.step_pulse), 2'd0);
        chk("arst_giro2", bif.giro,           2'd0);
        reset = 1'b0;
        run(1);

        // Exact thresholds and hysteresis boundaries
        send_valid(8'd20);
        chk("b20", bif.target_lvl, 2'd1);
        send_valid(8'd18);
        chk("b18_hold", bif.target_lvl, 2'd1);
        send_valid(8'd17);
        chk("b17_drop", bif.target_lvl, 2'd0);
        send_valid(8'd26);
        chk("b26", bif.target_lvl, 2'd2);
        send_valid(8'd25);
        chk("b25_hold", bif.target_lvl, 2'd2);

`ifdef OVERTEMP_ALARM_EN
        send_valid(8'd40);
        chk("al40",   2'(bif.alarm),  2'd1);
        chk("al40_t", bif.target_lvl, 2'd3);
        send_valid(8'd39);
        chk("al39",   2'(bif.alarm),  2'd1);
        chk("al39_t", bif.target_lvl, 2'd3);
        send_valid(8'd37);
        chk("al37",   2'(bif.alarm),  2'd0);
        chk("al37_t", bif.target_lvl, 2'd3);
`else
        send_valid(8'd40);
        chk("al_off",   2'(bif.alarm),  2'd0);
        chk("al_off_t", bif.target_lvl, 2'd3);
`endif

        run(2);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
